// File: rtl/decryptor.sv
// decryptor: RC4 PRGA keystream generator that XORs the message ROM into the result RAM.
// Each byte takes 13 strictly sequenced cycles; memory reads have a two-cycle latency.
module decryptor #(
  parameter int RAM_WIDTH          = 8,
  parameter int RAM_LENGTH         = 8,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [RAM_WIDTH-1:0]          sOut,
  output logic [RAM_WIDTH-1:0]          sIn,
  output logic [RAM_LENGTH-1:0]         sAddr,
  output logic                          sWren,
  output logic [RAM_WIDTH-1:0]          aIn,
  output logic [RAM_LENGTH-1:0]         aAddr,
  output logic                          aWren,
  input  logic [RAM_WIDTH-1:0]          kOut,
  output logic [MESSAGE_LOG_LENGTH-1:0] kAddr,
  output logic [7:0]                    iTap,
  output logic [7:0]                    jTap,
  output logic [7:0]                    kTap,
  output logic [7:0]                    siTap,
  output logic [7:0]                    sjTap,
  output logic [7:0]                    stateTap
);
  typedef enum logic [3:0] {
    IDLE = 4'd0, RD_I = 4'd1, WT_I = 4'd2, GT_I = 4'd3, RD_J = 4'd4, WT_J = 4'd5,
    GT_J = 4'd6, WR_I = 4'd7, WR_J = 4'd8, RD_F = 4'd9, WT_F = 4'd10, GT_F = 4'd11,
    WR_A = 4'd12, NEXT = 4'd13, DONE = 4'd14
  } state_t;

  localparam logic [MESSAGE_LOG_LENGTH-1:0] LAST = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);

  state_t                        r_state, w_next;
  logic [RAM_LENGTH-1:0]         r_i, r_j;
  logic [MESSAGE_LOG_LENGTH-1:0] r_k;
  logic [RAM_WIDTH-1:0]          r_si, r_sj, r_result;
  logic [RAM_LENGTH-1:0]         w_f_addr;

  assign w_f_addr = RAM_LENGTH'(r_si + r_sj);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_si     <= '0;
      r_sj     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_i <= RAM_LENGTH'(1);
          r_j <= '0;
          r_k <= '0;
        end
        GT_I: begin
          r_si <= sOut;
          r_j  <= r_j + RAM_LENGTH'(sOut);
        end
        GT_J: r_sj <= sOut;
        GT_F: r_result <= sOut ^ kOut;
        NEXT: if (r_k != LAST) begin
          r_k <= r_k + 1'b1;
          r_i <= r_i + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Every state except IDLE/NEXT/DONE simply advances to the next code.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RD_I : IDLE;
      NEXT:    w_next = (r_k == LAST) ? DONE : RD_I;
      DONE:    w_next = DONE;
      default: w_next = state_t'(r_state + 4'd1);
    endcase
  end

  always_comb begin
    sIn   = '0;
    sAddr = '0;
    sWren = 1'b0;
    aIn   = '0;
    aAddr = '0;
    aWren = 1'b0;
    kAddr = '0;
    case (r_state)
      RD_I, WT_I, GT_I: sAddr = r_i;
      RD_J, WT_J, GT_J: sAddr = r_j;
      WR_I: begin
        sAddr = r_i;
        sIn   = r_sj;
        sWren = 1'b1;
      end
      WR_J: begin
        sAddr = r_j;
        sIn   = r_si;
        sWren = 1'b1;
      end
      RD_F, WT_F, GT_F: begin
        sAddr = w_f_addr;
        kAddr = r_k;
      end
      WR_A: begin
        aAddr = RAM_LENGTH'(r_k);
        aIn   = r_result;
        aWren = 1'b1;
      end
      default: ;
    endcase
  end

  assign iTap     = 8'(r_i);
  assign jTap     = 8'(r_j);
  assign kTap     = 8'(r_k);
  assign siTap    = 8'(r_si);
  assign sjTap    = 8'(r_sj);
  assign stateTap = 8'(r_state);
endmodule

// File: tb/tb_decryptor.sv
// tb_decryptor: directed checks of the RC4 decryptor against hand-computed values,
// using a fixed S/ROM pattern and a small identity-initialised S RAM model.
module tb_decryptor;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] sOut, sIn, sAddr, aIn, aAddr, kOut;
  logic       sWren, aWren;
  logic [4:0] kAddr;
  logic [7:0] iTap, jTap, kTap, siTap, sjTap, stateTap;
  logic       use_model = 1'b0;
  logic       load = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] q;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  decryptor dut (
    .clk(clk), .reset(reset), .start(start), .sOut(sOut), .sIn(sIn), .sAddr(sAddr),
    .sWren(sWren), .aIn(aIn), .aAddr(aAddr), .aWren(aWren), .kOut(kOut), .kAddr(kAddr),
    .iTap(iTap), .jTap(jTap), .kTap(kTap), .siTap(siTap), .sjTap(sjTap), .stateTap(stateTap)
  );

  // Synchronous S RAM: data for an address appears after the next edge.
  always @(posedge clk) begin
    if (load) for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
    else if (sWren) mem[sAddr] <= sIn;
    q <= mem[sAddr];
  end

  assign sOut = use_model ? q : 8'h18;
  assign kOut = 8'h03;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic restart();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start = 1'b1;
  endtask

  // Full 32-byte run with sOut=0x18, kOut=0x03; start already set before the next edge.
  task automatic run_full(input string tag);
    int cyc = 0;
    int nw = 0;
    int bad_addr = 0, bad_data = 0, bad_j = 0, both = 0;
    while (cyc < 600 && stateTap != 8'd14) begin
      @(negedge clk);
      cyc++;
      if (sWren && aWren) both++;
      if (aWren) begin
        if (aAddr != 8'(nw)) bad_addr++;
        if (aIn != 8'h1B) bad_data++;
        if (jTap != 8'(8'h18 * (nw + 1))) bad_j++;
        nw++;
      end
    end
    chk({tag, "_done_cycles"}, cyc, 417);
    chk({tag, "_aw_pulses"}, nw, 32);
    chk({tag, "_aaddr_errs"}, bad_addr, 0);
    chk({tag, "_ain_errs"}, bad_data, 0);
    chk({tag, "_jtap_errs"}, bad_j, 0);
    chk({tag, "_wren_overlap"}, both, 0);
  endtask

  initial begin
    int cyc;
    int wa [2];
    int wd [2];
    int nws;
    logic hit;
    // Power-up in reset with start high: nothing moves.
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_state", stateTap, 0);
    chk("rst_outs", {sIn, sAddr, aIn, aAddr, 3'b0, kAddr, 6'b0, sWren, aWren}, 0);
    chk("rst_taps", {iTap, jTap, kTap, siTap ^ sjTap}, 0);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_i", iTap, 1);
    start = 1'b1;
    // First byte cycle by cycle.
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1)  chk("b0_rdi_addr", sAddr, 8'h01);
      if (c == 4)  chk("b0_rdj_addr", {sAddr, jTap}, 16'h1818);
      if (c == 7)  chk("b0_wri", {sWren, sAddr, sIn}, {1'b1, 16'h0118});
      if (c == 8)  chk("b0_wrj", {sWren, sAddr, sIn}, {1'b1, 16'h1818});
      if (c == 9)  chk("b0_rdf", {sAddr, 3'b0, kAddr}, 16'h3000);
      if (c == 12) chk("b0_wra", {aWren, aAddr, aIn}, {1'b1, 16'h001B});
    end
    restart();
    run_full("run1");
    // DONE ignores a held start.
    cyc = 0;
    repeat (20) begin
      @(negedge clk);
      if (sWren || aWren || stateTap != 8'd14) cyc++;
    end
    chk("done_quiet", cyc, 0);
    restart();
    run_full("run2");
    // Reset mid-swap at k=10.
    restart();
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      hit = (kTap == 8'd10) && sWren;
    end
    chk("k10_reached", hit, 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_swren", sWren, 0);
    chk("midrst_taps", {iTap, jTap, kTap, siTap, sjTap, stateTap}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      hit = aWren;
    end
    chk("post_rst_aw", hit, 1);
    chk("post_rst_aaddr", aAddr, 0);
    // i==j=1 through the S RAM model seeded with s[x]=x.
    start = 1'b0;
    use_model = 1'b1;
    load = 1'b1;
    restart();
    load = 1'b0;
    nws = 0;
    hit = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      if (sWren && nws < 2) begin
        wa[nws] = int'(sAddr);
        wd[nws] = int'(sIn);
        nws++;
      end
      hit = aWren;
    end
    chk("ij_writes", nws, 2);
    chk("ij_addr_i", wa[0], 1);
    chk("ij_addr_j", wa[1], 1);
    chk("ij_final_data", wd[1], 1);
    chk("ij_mem1", mem[1], 1);
    chk("ij_ain", {aWren, aIn}, {1'b1, 8'h01});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
